ex_div_seq: RTL and testbench
=============================

# ex_div_seq

Iterative divide sequencer for the EX stage: executes RV32M DIV/DIVU/REM/REMU over multiple cycles with a radix-2 restoring divider, and holds the pipeline with a stall while it works. It sits beside the ALU in EX. Operands come from the forwarded EX register data. The result is muxed onto the EX result path in the cycle `result_valid` is high. The pipeline flush aborts an in-flight divide.

## Interface
- `XLEN`, 32: operand/result width; the counter width is clog2(XLEN)+1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  EX holds a valid divide instruction (decoded from ALUOp).
- `op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_data`  in  XLEN  dividend.
- `rs2_data`  in  XLEN  divisor.
- `flush`  in  1  pipeline flush (branch/trap), kills the operation.
- `stall`  out  1  freezes IF/ID/EX and inserts a bubble into MEM.
- `busy`  out  1  FSM is not in IDLE.
- `result_valid`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  quotient or remainder.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE, start=1, flush=0, normal case:**
  - latch `op` and sign flags;
  - latch |rs1| and |rs2| (absolute value only for signed ops);
  - clear the remainder register and the counter;
  - go to CALC.
- **IDLE, start=1, flush=0, special case:** precompute the result and go straight to DONE.
  - Divide by zero (rs2=0): quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- **CALC:** one quotient bit per cycle.
  - Shift {rem, dividend} left by 1.
  - If rem ≥ divisor: subtract, quotient bit = 1.
  - Counter increments. After XLEN iterations (counter = XLEN-1 processed), go to DONE.
- **Sign fix, applied when entering DONE for signed ops:**
  - quotient is negated if the operand signs differ;
  - remainder takes the dividend's sign.
  - Arithmetic is two's complement, XLEN bits, no wider intermediates except the XLEN+1-bit subtract.
- **DONE:** `result_valid`=1, `result` = quotient (op[1]=0) or remainder (op[1]=1). Next state is IDLE unconditionally.
  - A new `start` in the following cycle is a new instruction, because the pipeline advances during DONE.
- **`stall`** (combinational) = (state==IDLE & start & ~flush) | (state==CALC).
  - It is low in DONE, so EX advances with the result.
  - It is forced 0 while `rst`=1.
- **`flush`:**
  - In any state it forces next state IDLE.
  - It suppresses `result_valid` if asserted in DONE.
  - Flush has priority over `start`.
- `start` is ignored in CALC and DONE.
- Operand inputs are sampled only at the IDLE→CALC/DONE transition. Later changes have no effect.

## Timing
- **Reset values:** state IDLE, counter 0, `result` 0, `result_valid` 0, `busy` 0, `stall` 0.
- Reset mid-CALC aborts immediately (asynchronous). No `result_valid` is produced.
- **Normal latency:**
  - start seen in IDLE at cycle 0;
  - CALC in cycles 1..XLEN;
  - DONE in cycle XLEN+1 (33 for XLEN=32).
  - `stall` is high for cycles 0..XLEN (33 cycles).
- **Fast path:** start at cycle 0, DONE at cycle 1, `stall` high for 1 cycle.
- **Throughput:** back-to-back divides. The next start is accepted in the cycle after DONE, with no idle gap beyond that.
- `busy` is high in CALC and DONE, and low in IDLE.
- `result` holds its last value after DONE until the next DONE. Consumers qualify it with `result_valid`.

## Test plan
- DIVU 100/7 (start 1 cycle):
  - `stall` high 33 cycles;
  - cycle 33 `result_valid`=1, `result`=14;
  - repeat with REMU: `result`=2.
- Signed cases:
  - DIV −7/2 → 0xFFFFFFFD (−3);
  - REM −7/2 → 0xFFFFFFFF (−1);
  - REM 7/−2 → 1.
  - All at cycle 33.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5;
  - both at cycle 1, `stall` high exactly 1 cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; both at cycle 1.
- Flush:
  - DIV started, `flush` at cycle 10: IDLE at cycle 11, `stall`/`busy` low, no `result_valid`;
  - start+flush in the same cycle: not accepted.
- Back-to-back and reset:
  - DIVU 9/3 then REMU 9/4 issued the cycle after the first DONE: results 3 then 1, DONE at cycles 33 and 67;
  - async `rst` pulse at cycle 5: all outputs 0 within the same cycle.

Source files
------------

// File: rtl/ex_div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
// Stalls the pipeline while it iterates; special cases finish in a single cycle.
module ex_div_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sel_rem_q, sel_rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            signed_s, a_neg_s, b_neg_s, div_zero_s, ovf_s, take_s;
   logic [XLEN-1:0] a_abs_s, b_abs_s, rem_next_s, quo_next_s, rem_fix_s, quo_fix_s;
   logic [XLEN:0]   trial_s;

   assign signed_s   = ~op_i[0];
   assign a_neg_s    = signed_s & rs1_data_i[XLEN-1];
   assign b_neg_s    = signed_s & rs2_data_i[XLEN-1];
   assign a_abs_s    = a_neg_s ? ({XLEN{1'b0}} - rs1_data_i) : rs1_data_i;
   assign b_abs_s    = b_neg_s ? ({XLEN{1'b0}} - rs2_data_i) : rs2_data_i;
   assign div_zero_s = (rs2_data_i == {XLEN{1'b0}});
   assign ovf_s      = signed_s & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                                & (rs2_data_i == {XLEN{1'b1}});

   // The shifted partial remainder needs XLEN+1 bits; a clear top bit means rem >= divisor.
   assign trial_s    = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
   assign take_s     = ~trial_s[XLEN];
   assign rem_next_s = take_s ? trial_s[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
   assign quo_next_s = {quo_q[XLEN-2:0], take_s};
   assign quo_fix_s  = neg_quo_q ? ({XLEN{1'b0}} - quo_next_s) : quo_next_s;
   assign rem_fix_s  = neg_rem_q ? ({XLEN{1'b0}} - rem_next_s) : rem_next_s;

   assign stall_o        = ~rst_i & (((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_CALC));
   assign busy_o         = (state_q != S_IDLE);
   assign result_valid_o = (state_q == S_DONE) & ~flush_i;
   assign result_o       = result_q;

   // Next-state and datapath updates; flush overrides everything and freezes the datapath.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      sel_rem_d = sel_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  sel_rem_d = op_i[1];
                  neg_quo_d = a_neg_s ^ b_neg_s;
                  neg_rem_d = a_neg_s;
                  quo_d     = a_abs_s;
                  dvs_d     = b_abs_s;
                  rem_d     = {XLEN{1'b0}};
                  cnt_d     = {CW{1'b0}};
                  if (div_zero_s) begin
                     result_d = op_i[1] ? rs1_data_i : {XLEN{1'b1}};
                     state_d  = S_DONE;
                  end else if (ovf_s) begin
                     result_d = op_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_CALC;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CALC: begin
               rem_d = rem_next_s;
               quo_d = quo_next_s;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN - 1)) begin
                  result_d = sel_rem_q ? rem_fix_s : quo_fix_s;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rem_q     <= {XLEN{1'b0}};
         quo_q     <= {XLEN{1'b0}};
         dvs_q     <= {XLEN{1'b0}};
         cnt_q     <= {CW{1'b0}};
         sel_rem_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= {XLEN{1'b0}};
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         sel_rem_q <= sel_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed self-checking bench for ex_div_seq: latency, stall length, results,
// special cases, flush, back-to-back issue and asynchronous reset.
module tb_ex_div_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   int cyc_abs  = 0;
   int done_abs = 0;
   int base_abs = 0;

   ex_div_seq #(.XLEN(32)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .op_i           (op),
      .rs1_data_i     (rs1),
      .rs2_data_i     (rs2),
      .flush_i        (flush),
      .stall_o        (stall),
      .busy_o         (busy),
      .result_valid_o (result_valid),
      .result_o       (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc_abs++;
   endtask

   // Issue one op at the current cycle, follow it to DONE, then check the cycle after.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string tag);
      int n;
      int sc;
      bit got;
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      #1;
      n = 0; sc = 0; got = 1'b0;
      while (n < 100 && !got) begin
         if (stall === 1'b1) sc++;
         if (result_valid === 1'b1) begin
            got = 1'b1;
         end else begin
            step();
            start = 1'b0;
            op  = 2'($urandom);
            rs1 = $urandom;
            rs2 = $urandom;
            n++;
            #1;
         end
      end
      done_abs = cyc_abs;
      chk({tag, " valid_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(n), 32'(lat));
      chk({tag, " result"}, result, exp);
      chk({tag, " stall_cycles"}, 32'(sc), 32'(lat));
      chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
      step();
      chk({tag, " busy_after"}, 32'(busy), 32'd0);
      chk({tag, " valid_after"}, 32'(result_valid), 32'd0);
      chk({tag, " result_hold"}, result, exp);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0; flush = 1'b0;
      #2;
      chk("reset stall", 32'(stall), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset valid", 32'(result_valid), 32'd0);
      chk("reset result", result, 32'd0);
      step();
      rst = 1'b0;
      step();

      run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      run_op(2'b11, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
      run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
      run_op(2'b10, 32'd5, 32'd0, 32'd5, 1, "rem_5_0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

      // Back-to-back: second start issued in the cycle right after the first DONE.
      base_abs = cyc_abs;
      run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, "b2b_divu_9_3");
      chk("b2b first_done_cycle", 32'(done_abs - base_abs), 32'd33);
      run_op(2'b11, 32'd9, 32'd4, 32'd1, 33, "b2b_remu_9_4");
      chk("b2b second_done_cycle", 32'(done_abs - base_abs), 32'd67);

      // Flush at cycle 10 of a signed divide.
      op = 2'b00; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 10; i++) step();
      flush = 1'b1;
      #1;
      chk("flush busy_at_10", 32'(busy), 32'd1);
      step();
      flush = 1'b0;
      #1;
      chk("flush busy_at_11", 32'(busy), 32'd0);
      chk("flush stall_at_11", 32'(stall), 32'd0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (result_valid === 1'b1) seen++;
            step();
         end
         chk("flush no_valid", 32'(seen), 32'd0);
      end

      // start together with flush is not accepted.
      op = 2'b01; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1; flush = 1'b1;
      #1;
      chk("start_flush stall", 32'(stall), 32'd0);
      step();
      start = 1'b0; flush = 1'b0;
      #1;
      chk("start_flush busy", 32'(busy), 32'd0);
      chk("start_flush valid", 32'(result_valid), 32'd0);

      // Flush in DONE suppresses result_valid.
      op = 2'b01; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 33; i++) step();
      chk("done_flush valid_pre", 32'(result_valid), 32'd1);
      chk("done_flush result", result, 32'd10);
      flush = 1'b1;
      #1;
      chk("done_flush valid_suppressed", 32'(result_valid), 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("done_flush idle", 32'(busy), 32'd0);

      // Asynchronous reset pulse at cycle 5 of a divide.
      op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 5; i++) step();
      chk("rst_pre busy", 32'(busy), 32'd1);
      start = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst valid", 32'(result_valid), 32'd0);
      chk("rst result", result, 32'd0);
      start = 1'b0;
      step();
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            step();
            if (result_valid === 1'b1) seen++;
         end
         chk("rst no_valid", 32'(seen), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
